// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Display outputs update only when a conversion completes and saturate on overflow.
module bin_to_bcd_seq #(
    parameter int IN_W  = 16,
    parameter int N_DIG = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_W-1:0]      bin_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*N_DIG-1:0]   bcd_out,
    output logic [15:0]          disp_out,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [IN_W-1:0]      shreg_q, shreg_d;
    logic [4*N_DIG-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4*N_DIG-1:0]   bcd_q, bcd_d;
    logic [15:0]          disp_q, disp_d;
    logic                 ovf_q, ovf_d;

    logic [4*N_DIG-1:0]   scr_corr;
    logic [4*N_DIG-1:0]   scr_shift;
    logic [IN_W-1:0]      sh_shift;
    logic                 ovf_calc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        // Every digit is corrected from the same pre-shift scratch value.
        scr_corr = scr_q;
        for (int unsigned i = 0; i < N_DIG; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_corr[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        {scr_shift, sh_shift} = {scr_corr[4*N_DIG-2:0], shreg_q, 1'b0};

        ovf_calc = 1'b0;
        for (int unsigned i = 4; i < N_DIG; i++) begin
            if (scr_shift[4*i +: 4] != 4'd0) begin
                ovf_calc = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = bin_in;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(IN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = sh_shift;
                scr_d   = scr_shift;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scr_shift;
                    ovf_d   = ovf_calc;
                    disp_d  = ovf_calc ? 16'h9999 : scr_shift[15:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_q;
    assign disp_out  = disp_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed scenarios plus random values checked
// against an arithmetic decimal-digit model.
module tb_bin_to_bcd_seq;

    localparam int IN_W  = 16;
    localparam int N_DIG = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [IN_W-1:0]     bin_in;
    logic                in_valid;
    logic                in_ready;
    logic [4*N_DIG-1:0]  bcd_out;
    logic [15:0]         disp_out;
    logic                ovf;
    logic                out_valid;
    logic                out_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [19:0] prev_bcd;
    logic [15:0] prev_disp;
    logic        prev_ovf;

    bin_to_bcd_seq #(.IN_W(IN_W), .N_DIG(N_DIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .disp_out  (disp_out),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_disp(input int unsigned v);
        logic [19:0] b;
        b = ref_bcd(v);
        return (v > 9999) ? 16'h9999 : b[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_bcd"},  32'(bcd_out),  32'(prev_bcd));
        chk({tag, "_disp"}, 32'(disp_out), 32'(prev_disp));
        chk({tag, "_ovf"},  32'(ovf),      32'(prev_ovf));
    endtask

    // Time on entry and exit: 1 ns after a rising edge.
    task automatic convert(input int unsigned v, input int stall, input bit poke);
        int k;
        int budget;
        budget = 0;
        while (!in_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        bin_in    = v[IN_W-1:0];
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 40) begin
            chk_held("stable_shift");
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 32'(k), 32'(IN_W));
        prev_bcd  = ref_bcd(v);
        prev_disp = ref_disp(v);
        prev_ovf  = (v > 9999);
        chk_held("result");
        chk("done_in_ready", 32'(in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                bin_in   = 16'd777;
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk_held("stall");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk_held("release");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int last;
        int k;
        bit seen;

        rst       = 1'b0;
        bin_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        prev_bcd  = '0;
        prev_disp = '0;
        prev_ovf  = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk_held("rst");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // T1..T3: directed values including overflow boundaries
        convert(0, 0, 1'b0);
        convert(48, 0, 1'b0);
        convert(9999, 0, 1'b0);
        convert(10000, 0, 1'b0);
        convert(65535, 0, 1'b0);

        // T4: backpressure with a competing input that must be ignored
        convert(1234, 10, 1'b1);
        convert(777, 0, 1'b0);

        // T5: reset mid-conversion after a prior result of 48
        convert(48, 0, 1'b0);
        bin_in   = 16'd4321;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        prev_bcd  = '0;
        prev_disp = '0;
        prev_ovf  = 1'b0;
        chk_held("midreset");
        chk("midreset_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no_valid_after_reset", 32'(seen), 32'd0);
        chk("idle_after_reset", 32'(in_ready), 32'd1);

        // T6: back-to-back with in_valid held high
        in_valid  = 1'b1;
        out_ready = 1'b1;
        last = 0;
        for (int v = 1; v <= 5; v++) begin
            bin_in = 16'(v);
            @(posedge clk); #1;
            chk("b2b_busy", 32'(in_ready), 32'd0);
            k = 0;
            while (!out_valid && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_bcd", 32'(bcd_out), 32'(ref_bcd(v)));
            if (v > 1) chk("b2b_interval", 32'(cyc - last), 32'(IN_W + 2));
            last = cyc;
            @(posedge clk); #1;
            chk("b2b_idle", 32'(in_ready), 32'd1);
            chk("b2b_disp_stable", 32'(disp_out), 32'(ref_disp(v)));
        end
        in_valid  = 1'b0;
        prev_bcd  = ref_bcd(5);
        prev_disp = ref_disp(5);
        prev_ovf  = 1'b0;

        // Random values with random output stalls
        for (int n = 0; n < 20; n++) begin
            convert($urandom_range(0, 65535), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
